fp_add_arbiter: RTL and testbench
=================================

Name: fp_add_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one single-precision IEEE adder between NUM_REQ requesters.
- Accepts operand pairs from each requester and drives the adder's three-phase strobe/ack protocol: operand A, then operand B, then result Z.
- Returns each sum to a per-requester result register that is held until the requester consumes it.
- Sits between the compute clients and the shared adder instance. Both blocks run on the same clk and rst.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
CNT_W, 16, width of completed-operation counter

Ports:
clk  in  1  clock
rst  in  1  reset
req_valid  in  NUM_REQ  per-requester operand pair valid
req_a  in  32*NUM_REQ  operand A, requester i at bits [32i+31:32i]
req_b  in  32*NUM_REQ  operand B, same packing
req_ready  out  NUM_REQ  one-cycle pulse: operands of requester i captured
resp_valid  out  NUM_REQ  result pending for requester i
resp_z  out  32*NUM_REQ  result for requester i, same packing
resp_ready  in  NUM_REQ  requester i consumes its result
add_a  out  32  operand A to adder
add_a_stb  out  1  operand A strobe
add_a_ack  in  1  adder accepted A
add_b  out  32  operand B to adder
add_b_stb  out  1  operand B strobe
add_b_ack  in  1  adder accepted B
add_z  in  32  adder result
add_z_stb  in  1  adder result valid
add_z_ack  out  1  result accept
busy  out  1  operation in flight (state != IDLE)
cur_id  out  3  index of requester currently being served
ops_done  out  CNT_W  completed-operation count, wraps modulo 2^CNT_W

Behaviour:
- Reset is synchronous and active-high on rst, clocked on clk. Reset values:
  - state=IDLE; req_ready=0; resp_valid=0; resp_z=0.
  - add_a_stb=add_b_stb=add_z_ack=0; busy=0; cur_id=0; ops_done=0.
  - last_grant=NUM_REQ-1, so requester 0 wins first.
- Eligibility: requester i is eligible when req_valid[i] && !resp_valid[i], evaluated on registered resp_valid. A requester with an unconsumed result is never granted.
- Grant priority is round-robin: search starts at last_grant+1, modulo NUM_REQ.
- IDLE:
  - If any requester is eligible, latch its req_a/req_b into internal op registers, set cur_id and last_grant to the winner.
  - Pulse req_ready[winner] for exactly one cycle, then go to SEND_A.
  - The requester may drop or change its operands after the pulse.
- SEND_A: add_a_stb=1, add_a=latched A. On add_a_ack=1, go to SEND_B; add_a_stb is 0 from the next cycle.
- SEND_B: add_b_stb=1, add_b=latched B. On add_b_ack=1, go to WAIT_Z.
- WAIT_Z:
  - add_z_ack=1 (combinational decode of state).
  - On add_z_stb=1: capture add_z into resp_z[cur_id], set resp_valid[cur_id], increment ops_done, go to IDLE.
  - The adder sees stb && ack in that cycle and returns to its own idle state.
- add_a_stb, add_b_stb and add_z_ack are decoded from state only and are never high in IDLE. At most one of them is high in any cycle.
- Response side:
  - resp_valid[i] clears on resp_valid[i] && resp_ready[i]. resp_z[i] holds its value.
  - Clearing is independent of the arbiter state; several requesters may drain in the same cycle.
  - Set and clear on the same index cannot coincide, because a pending index is never granted.
- Arbiter overhead per operation: 1 cycle in IDLE plus the adder's handshake latency. With continuous demand, back-to-back grants have no extra idle cycles beyond the single IDLE cycle.
- No timeout is required: the arbiter waits indefinitely in SEND_A, SEND_B and WAIT_Z.
- Reset mid-operation: the arbiter returns to IDLE and the in-flight operation is dropped with no response. The adder shares rst, so both return to idle together. Requesters must reissue.
- ops_done wraps from 2^CNT_W-1 to 0 with no saturation.
- Unused cur_id bits are 0.

Test Plan:
- Single op: requester 0 sends A=0x3F800000, B=0x40000000.
  - Required: req_ready[0] pulses once, and a_stb, b_stb, z_ack are asserted in order.
  - Required: resp_valid[0]=1, resp_z[0]=0x40400000, ops_done=1.
- Fairness: all four requesters continuously valid and always ready.
  - Required grant order: 0,1,2,3,0,1,2,3.
  - Required: no requester is granted twice before all others have been served once.
- Back-pressure: requester 1 holds resp_ready=0 with req_valid[1] still high after a completed op.
  - Required: requester 1 is skipped and requesters 0, 2 and 3 are served.
  - Required: one cycle after resp_ready[1] is pulsed, requester 1 becomes eligible again.
- Handshake timing: bench adder model delays add_a_ack by 5 cycles and add_z_stb by 10 cycles.
  - Required: each strobe is held until its ack, never overlaps another strobe, and the result is captured exactly once.
- Reset mid-op: assert rst while in WAIT_Z.
  - Required next cycle: busy=0, all resp_valid=0, ops_done=0.
  - Required afterwards: the next request completes correctly (0xC0000000 + 0x40000000 -> 0x00000000).
- Counter wrap: with CNT_W=4, run 17 operations. Required: ops_done=1.

Source files
------------

// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter that shares one IEEE-754 single-precision adder between NUM_REQ clients.
// It drives the adder's A / B / Z strobe-ack sequence and holds each result until its client consumes it.
module fp_add_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [32*NUM_REQ-1:0] req_a,
  input  logic [32*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    resp_valid,
  output logic [32*NUM_REQ-1:0] resp_z,
  input  logic [NUM_REQ-1:0]    resp_ready,
  output logic [31:0]           add_a,
  output logic                  add_a_stb,
  input  logic                  add_a_ack,
  output logic [31:0]           add_b,
  output logic                  add_b_stb,
  input  logic                  add_b_ack,
  input  logic [31:0]           add_z,
  input  logic                  add_z_stb,
  output logic                  add_z_ack,
  output logic                  busy,
  output logic [2:0]            cur_id,
  output logic [CNT_W-1:0]      ops_done
);

  // state  | meaning
  // IDLE   | pick next eligible requester, latch its operands, pulse req_ready
  // SEND_A | present operand A until the adder acks it
  // SEND_B | present operand B until the adder acks it
  // WAIT_Z | accept the sum and file it in the winner's result slot
  typedef enum logic [1:0] {IDLE, SEND_A, SEND_B, WAIT_Z} state_t;

  state_t             state_q, state_d;
  logic [2:0]         last_grant_q, last_grant_d;
  logic [2:0]         cur_id_q, cur_id_d;
  logic [31:0]        op_a_q, op_a_d;
  logic [31:0]        op_b_q, op_b_d;
  logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
  logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
  logic [31:0]        resp_z_q [NUM_REQ];
  logic [31:0]        resp_z_d [NUM_REQ];
  logic [CNT_W-1:0]   ops_q, ops_d;

  logic [NUM_REQ-1:0] elig;
  logic               grant_found;
  logic [2:0]         grant_id;

  // A client still holding an unconsumed result must not be granted again.
  assign elig = req_valid & ~resp_valid_q;

  // Two passes: indices above last_grant first, then wrap to the lowest eligible index.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      if (elig[i] && (i > int'(last_grant_q))) begin
        grant_found = 1'b1;
        grant_id    = i[2:0];
      end
    end
    if (!grant_found) begin
      for (int i = NUM_REQ-1; i >= 0; i--) begin
        if (elig[i]) begin
          grant_found = 1'b1;
          grant_id    = i[2:0];
        end
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cur_id_d     = cur_id_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    req_ready_d  = '0;
    ops_d        = ops_q;
    resp_valid_d = resp_valid_q & ~resp_ready;
    resp_z_d     = resp_z_q;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          state_d      = SEND_A;
          last_grant_d = grant_id;
          cur_id_d     = grant_id;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == i[2:0]) begin
              op_a_d         = req_a[32*i +: 32];
              op_b_d         = req_b[32*i +: 32];
              req_ready_d[i] = 1'b1;
            end
          end
        end
      end
      SEND_A: if (add_a_ack) state_d = SEND_B;
      SEND_B: if (add_b_ack) state_d = WAIT_Z;
      WAIT_Z: begin
        if (add_z_stb) begin
          state_d = IDLE;
          ops_d   = ops_q + CNT_W'(1);
          for (int i = 0; i < NUM_REQ; i++) begin
            if (cur_id_q == i[2:0]) begin
              resp_valid_d[i] = 1'b1;
              resp_z_d[i]     = add_z;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 3'(NUM_REQ-1);
      cur_id_q     <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      req_ready_q  <= '0;
      resp_valid_q <= '0;
      ops_q        <= '0;
      for (int i = 0; i < NUM_REQ; i++) resp_z_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cur_id_q     <= cur_id_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      ops_q        <= ops_d;
      resp_z_q     <= resp_z_d;
    end
  end

  always_comb begin
    resp_z = '0;
    for (int i = 0; i < NUM_REQ; i++) resp_z[32*i +: 32] = resp_z_q[i];
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign add_a      = op_a_q;
  assign add_b      = op_b_q;
  assign add_a_stb  = (state_q == SEND_A);
  assign add_b_stb  = (state_q == SEND_B);
  assign add_z_ack  = (state_q == WAIT_Z);
  assign busy       = (state_q != IDLE);
  assign cur_id     = cur_id_q;
  assign ops_done   = ops_q;

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Scoreboard bench for fp_add_arbiter: a queued requester driver, a table-driven adder model
// with programmable ack delays, and a monitor that checks grants and results as they appear.
module tb_fp_add_arbiter;
  localparam int NR = 4;
  localparam int CW = 4;
  localparam int NV = 9;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_valid, req_ready, resp_valid, resp_ready;
  logic [32*NR-1:0] req_a, req_b, resp_z;
  logic [31:0]     add_a, add_b, add_z;
  logic            add_a_stb, add_a_ack, add_b_stb, add_b_ack, add_z_stb, add_z_ack;
  logic            busy;
  logic [2:0]      cur_id;
  logic [CW-1:0]   ops_done;

  fp_add_arbiter #(.NUM_REQ(NR), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_z(resp_z), .resp_ready(resp_ready),
    .add_a(add_a), .add_a_stb(add_a_stb), .add_a_ack(add_a_ack),
    .add_b(add_b), .add_b_stb(add_b_stb), .add_b_ack(add_b_ack),
    .add_z(add_z), .add_z_stb(add_z_stb), .add_z_ack(add_z_ack),
    .busy(busy), .cur_id(cur_id), .ops_done(ops_done)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] a; logic [31:0] b; logic [31:0] z; } vec_t;
  typedef struct { int id; logic [31:0] a; logic [31:0] b; logic [31:0] z; } op_t;

  vec_t vt [NV];
  op_t  pend [$];
  op_t  expz [$];
  int   exp_grant [$];

  int   checks = 0;
  int   failures = 0;
  int   exp_ops = 0;
  logic [NR-1:0] rr_mask = '0;

  int   a_dly = 0, b_dly = 0, z_dly = 0;
  int   mst = 0, cnt = 0, seen = 0;
  int   z_xfers = 0, a_hi = 0;
  logic [31:0] lat_a, lat_b;

  function automatic logic [31:0] fp_lookup(input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < NV; i++)
      if (vt[i].a == a && vt[i].b == b) return vt[i].z;
    return 32'h7FC00000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input int id, input int v);
    op_t o;
    o.id = id; o.a = vt[v].a; o.b = vt[v].b; o.z = vt[v].z;
    pend.push_back(o);
    expz.push_back(o);
    exp_ops++;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    pend.delete(); expz.delete(); exp_grant.delete();
    exp_ops = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((pend.size() != 0 || expz.size() != 0 || exp_grant.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL %s: drain timeout after %0d cycles, pending results %0d", name, n, expz.size());
    end
  endtask

  // Requester driver: retire an op when its req_ready pulse is seen, present the next queued op.
  initial begin
    req_valid = '0; req_a = '0; req_b = '0; resp_ready = '0;
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < NR; i++)
        if (req_ready[i])
          for (int k = 0; k < pend.size(); k++)
            if (pend[k].id == i) begin pend.delete(k); break; end
      for (int i = 0; i < NR; i++) begin
        req_valid[i] = 1'b0; req_a[32*i +: 32] = '0; req_b[32*i +: 32] = '0;
        for (int k = 0; k < pend.size(); k++)
          if (pend[k].id == i) begin
            req_valid[i] = 1'b1; req_a[32*i +: 32] = pend[k].a; req_b[32*i +: 32] = pend[k].b;
            break;
          end
      end
      resp_ready = rr_mask;
    end
  end

  // Adder model plus per-cycle protocol checks.
  initial begin
    logic bad;
    add_a_ack = 1'b0; add_b_ack = 1'b0; add_z_stb = 1'b0; add_z = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        add_a_ack = 1'b0; add_b_ack = 1'b0; add_z_stb = 1'b0;
        mst = 0; cnt = 0; seen = 0;
      end else begin
        bad = ($countones({add_a_stb, add_b_stb, add_z_ack}) > 1) ||
              (!busy && (add_a_stb || add_b_stb || add_z_ack));
        case (mst)
          0: if (add_a_ack) begin
               add_a_ack = 1'b0; mst = 1; cnt = 0; seen = 0;
             end else begin
               if (add_b_stb || add_z_ack) bad = 1'b1;
               if (add_a_stb) begin
                 a_hi++;
                 if (seen != 0 && add_a != lat_a) bad = 1'b1;
                 seen = 1; lat_a = add_a;
                 if (cnt >= a_dly) add_a_ack = 1'b1; else cnt++;
               end else if (seen != 0) bad = 1'b1;
             end
          1: if (add_b_ack) begin
               add_b_ack = 1'b0; mst = 2; cnt = 0; seen = 0;
             end else begin
               if (add_a_stb || add_z_ack) bad = 1'b1;
               if (add_b_stb) begin
                 if (seen != 0 && add_b != lat_b) bad = 1'b1;
                 seen = 1; lat_b = add_b;
                 if (cnt >= b_dly) add_b_ack = 1'b1; else cnt++;
               end else if (seen != 0) bad = 1'b1;
             end
          2: begin
               if (!add_z_ack) bad = 1'b1;
               if (cnt >= z_dly) begin
                 add_z = fp_lookup(lat_a, lat_b); add_z_stb = 1'b1; mst = 3;
               end else cnt++;
             end
          default: begin
               add_z_stb = 1'b0; mst = 0; cnt = 0; z_xfers++;
             end
        endcase
        checks++;
        if (bad) begin
          failures++;
          $display("FAIL protocol: a_stb=%b b_stb=%b z_ack=%b busy=%b model_phase=%0d", add_a_stb, add_b_stb, add_z_ack, busy, mst);
        end
      end
    end
  end

  // Monitor: every grant pops the expected-grant queue, every consumed result pops its expected sum.
  initial begin
    int g, idx;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (req_ready != '0) begin
          checks++;
          if (exp_grant.size() == 0) begin
            failures++;
            $display("FAIL grant_unexpected: got req_ready=%b expected no grant", req_ready);
          end else begin
            g = exp_grant.pop_front();
            if (req_ready != NR'(1 << g)) begin
              failures++;
              $display("FAIL grant_order: got req_ready=%b expected requester %0d", req_ready, g);
            end
          end
        end
        for (int i = 0; i < NR; i++) begin
          if (resp_valid[i] && resp_ready[i]) begin
            checks++;
            idx = -1;
            for (int k = 0; k < expz.size(); k++)
              if (expz[k].id == i) begin idx = k; break; end
            if (idx < 0) begin
              failures++;
              $display("FAIL result_unexpected: requester %0d got %h with no result expected", i, resp_z[32*i +: 32]);
            end else begin
              if (resp_z[32*i +: 32] !== expz[idx].z) begin
                failures++;
                $display("FAIL result_z: requester %0d got %h expected %h", i, resp_z[32*i +: 32], expz[idx].z);
              end
              expz.delete(idx);
            end
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, zx0, ah0;
    vt[0] = '{32'h3F800000, 32'h40000000, 32'h40400000};
    vt[1] = '{32'hC0000000, 32'h40000000, 32'h00000000};
    vt[2] = '{32'h3F800000, 32'h3F800000, 32'h40000000};
    vt[3] = '{32'h40000000, 32'h40000000, 32'h40800000};
    vt[4] = '{32'h3FC00000, 32'h3F000000, 32'h40000000};
    vt[5] = '{32'h40400000, 32'h3F800000, 32'h40800000};
    vt[6] = '{32'h3F000000, 32'h3E800000, 32'h3F400000};
    vt[7] = '{32'h3F800000, 32'hBF000000, 32'h3F000000};
    vt[8] = '{32'h40800000, 32'h40800000, 32'h41000000};
    rst = 1'b1;

    // Reset state
    reset_dut();
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_strobes", 32'({add_a_stb, add_b_stb, add_z_ack}), 32'd0);
    chk("rst_cur_id", 32'(cur_id), 32'd0);
    chk("rst_ops_done", 32'(ops_done), 32'd0);
    chk("rst_resp_z", resp_z[31:0], 32'd0);

    // Single op on requester 0, result held until consumed
    a_dly = 1; b_dly = 1; z_dly = 2;
    rr_mask = 4'b0000;
    zx0 = z_xfers;
    issue(0, 0); exp_grant.push_back(0);
    n = 0;
    while (!resp_valid[0] && n < 100) begin @(negedge clk); n++; end
    chk("single_timeout", 32'(n < 100), 32'd1);
    chk("single_resp_valid", 32'(resp_valid), 32'b0001);
    chk("single_resp_z", resp_z[31:0], 32'h40400000);
    chk("single_ops_done", 32'(ops_done), 32'd1);
    chk("single_z_xfers", 32'(z_xfers - zx0), 32'd1);
    chk("single_cur_id", 32'(cur_id), 32'd0);
    rr_mask = 4'b1111;
    wait_drain("single_drain", 100);

    // Fairness: all four continuously valid
    reset_dut();
    a_dly = 0; b_dly = 0; z_dly = 1;
    rr_mask = 4'b1111;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NR; i++) begin
        issue(i, (r*NR + i) % NV);
        exp_grant.push_back(i);
      end
    wait_drain("fair_drain", 400);
    chk("fair_ops_done", 32'(ops_done), 32'(exp_ops % 16));

    // Back-pressure: requester 1 withholds resp_ready
    reset_dut();
    rr_mask = 4'b1101;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NR; i++) issue(i, (r*NR + i + 3) % NV);
    exp_grant = '{0, 1, 2, 3, 0, 2, 3, 1};
    n = 0;
    while (!(exp_grant.size() == 1 && !busy && resp_valid == 4'b0010) && n < 400) begin
      @(negedge clk); n++;
    end
    chk("bp_timeout", 32'(n < 400), 32'd1);
    chk("bp_pending", 32'(resp_valid), 32'b0010);
    chk("bp_cur_id", 32'(cur_id), 32'd3);
    rr_mask = 4'b1111;
    @(negedge clk);
    rr_mask = 4'b1101;
    @(negedge clk);
    chk("bp_cleared", 32'(resp_valid), 32'b0000);
    chk("bp_no_early_grant", 32'(req_ready), 32'b0000);
    @(negedge clk);
    chk("bp_regrant", 32'(req_ready), 32'b0010);
    rr_mask = 4'b1111;
    wait_drain("bp_drain", 200);
    chk("bp_ops_done", 32'(ops_done), 32'(exp_ops % 16));

    // Slow adder handshakes
    reset_dut();
    a_dly = 5; b_dly = 0; z_dly = 10;
    rr_mask = 4'b1111;
    zx0 = z_xfers; ah0 = a_hi;
    issue(2, 6); exp_grant.push_back(2);
    issue(3, 7); exp_grant.push_back(3);
    wait_drain("slow_drain", 300);
    chk("slow_z_xfers", 32'(z_xfers - zx0), 32'd2);
    chk("slow_a_stb_cycles", 32'(a_hi - ah0), 32'd12);
    chk("slow_ops_done", 32'(ops_done), 32'd2);

    // Reset while waiting for Z
    reset_dut();
    a_dly = 0; b_dly = 0; z_dly = 30;
    rr_mask = 4'b0111;
    issue(3, 8); exp_grant.push_back(3);
    n = 0;
    while (!(resp_valid[3] && !busy) && n < 200) begin @(negedge clk); n++; end
    chk("rmid_pre_timeout", 32'(n < 200), 32'd1);
    issue(0, 2); exp_grant.push_back(0);
    n = 0;
    while (!add_z_ack && n < 100) begin @(negedge clk); n++; end
    chk("rmid_waitz_timeout", 32'(n < 100), 32'd1);
    rst = 1'b1;
    pend.delete(); expz.delete(); exp_grant.delete();
    exp_ops = 0;
    @(negedge clk);
    chk("rmid_busy", 32'(busy), 32'd0);
    chk("rmid_resp_valid", 32'(resp_valid), 32'd0);
    chk("rmid_ops_done", 32'(ops_done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    z_dly = 2;
    rr_mask = 4'b1111;
    issue(0, 1); exp_grant.push_back(0);
    wait_drain("rmid_drain", 200);
    chk("rmid_after_ops", 32'(ops_done), 32'd1);

    // Counter wrap with CNT_W=4
    reset_dut();
    a_dly = 0; b_dly = 0; z_dly = 0;
    rr_mask = 4'b1111;
    for (int k = 0; k < 17; k++) begin
      issue(k % NR, k % NV);
      exp_grant.push_back(k % NR);
    end
    wait_drain("wrap_drain", 2000);
    chk("wrap_ops_done", 32'(ops_done), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
